// File: rtl/stb_drain_ctl_pkg.sv
// stb_drain_ctl_pkg: shared sizes, types and drain FSM encoding for the store-buffer drain controller
package stb_drain_ctl_pkg;
    localparam int STB_THREADS = 8;
    localparam int STB_DEPTH   = 8;
    localparam int PTR_W       = $clog2(STB_DEPTH);
    localparam int TID_W       = $clog2(STB_THREADS);
    localparam int CNT_W       = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [TID_W-1:0] tid_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {DRN_IDLE, DRN_RD, DRN_WAIT} drain_state_e;

    function automatic logic [STB_DEPTH-1:0] ptr_onehot(ptr_t p);
        return {{(STB_DEPTH-1){1'b0}}, 1'b1} << p;
    endfunction
endpackage

// File: rtl/stb_drain_ctl_if.sv
// stb_drain_ctl_if: store allocate, drain handshake and CAM RW port bundle of the drain controller
interface stb_drain_ctl_if;
    import stb_drain_ctl_pkg::*;

    logic                   st_vld;
    tid_t                   st_tid;
    logic [STB_THREADS-1:0] flush;
    logic [STB_THREADS-1:0] drain_en;
    logic                   pcx_rdy;
    logic                   drain_ack;
    tid_t                   cam_tid;
    ptr_t                   stb_cam_rw_ptr;
    tid_t                   stb_cam_rw_tid;
    logic                   stb_cam_wptr_vld;
    logic                   stb_cam_rptr_vld;
    logic [STB_DEPTH-1:0]   stb_cam_line_en;
    logic [STB_THREADS-1:0] st_full;
    logic [STB_THREADS-1:0] stb_empty;
    logic                   drain_vld;
    tid_t                   drain_tid;
    ptr_t                   drain_ptr;

    modport master (
        output st_vld, st_tid, flush, drain_en, pcx_rdy, drain_ack, cam_tid,
        input  stb_cam_rw_ptr, stb_cam_rw_tid, stb_cam_wptr_vld, stb_cam_rptr_vld,
               stb_cam_line_en, st_full, stb_empty, drain_vld, drain_tid, drain_ptr
    );

    modport slave (
        input  st_vld, st_tid, flush, drain_en, pcx_rdy, drain_ack, cam_tid,
        output stb_cam_rw_ptr, stb_cam_rw_tid, stb_cam_wptr_vld, stb_cam_rptr_vld,
               stb_cam_line_en, st_full, stb_empty, drain_vld, drain_tid, drain_ptr
    );
endinterface

// File: rtl/stb_rr_arb8.sv
// stb_rr_arb8: 8-way round-robin arbiter, first requester at or after base wins
module stb_rr_arb8
    import stb_drain_ctl_pkg::*;
(
    input  logic [STB_THREADS-1:0] req,
    input  tid_t                   base,
    output logic                   gnt_vld,
    output tid_t                   gnt_tid
);
    // Scan from the farthest offset down so the nearest requester is written last
    always_comb begin
        gnt_vld = |req;
        gnt_tid = base;
        for (int i = STB_THREADS - 1; i >= 0; i--)
            if (req[base + tid_t'(i)]) gnt_tid = base + tid_t'(i);
    end
endmodule

// File: rtl/stb_drain_ctl.sv
// stb_drain_ctl: per-thread store-buffer pointer tracking and round-robin drain through a shared CAM RW port
module stb_drain_ctl
    import stb_drain_ctl_pkg::*;
(
    input logic            l2clk,
    input logic            reset,
    stb_drain_ctl_if.slave bus
);
    ptr_t                   wptr  [STB_THREADS];
    ptr_t                   rptr  [STB_THREADS];
    cnt_t                   cnt   [STB_THREADS];
    logic [STB_DEPTH-1:0]   valid [STB_THREADS];
    logic [STB_DEPTH-1:0]   set_m [STB_THREADS];
    logic [STB_DEPTH-1:0]   clr_m [STB_THREADS];
    logic [STB_THREADS-1:0] full, empty, elig, wr, rt;
    tid_t                   rr_ptr, d_tid, gnt_tid;
    ptr_t                   d_ptr;
    drain_state_e           state_q, state_d;
    logic                   st_acc, gnt_vld, launch, retire;

    always_comb begin
        for (int t = 0; t < STB_THREADS; t++) begin
            full[t]  = cnt[t] == cnt_t'(STB_DEPTH);
            empty[t] = cnt[t] == '0;
            elig[t]  = !empty[t] && bus.drain_en[t] && !bus.flush[t];
        end
    end

    // A store owns the RW port whenever it is accepted; reset blocks it outright
    assign st_acc = !reset && bus.st_vld && !full[bus.st_tid] && !bus.flush[bus.st_tid];

    stb_rr_arb8 u_arb (
        .req     (elig),
        .base    (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_tid (gnt_tid)
    );

    always_comb begin
        state_d       = state_q;
        launch        = 1'b0;
        retire        = 1'b0;
        bus.drain_vld = 1'b0;
        case (state_q)
            DRN_IDLE: begin
                launch  = !st_acc && bus.pcx_rdy && gnt_vld;
                state_d = launch ? DRN_RD : DRN_IDLE;
            end
            DRN_RD: begin
                bus.drain_vld = !bus.flush[d_tid];
                state_d       = bus.flush[d_tid] ? DRN_IDLE : DRN_WAIT;
            end
            DRN_WAIT: begin
                retire  = bus.drain_ack && !bus.flush[d_tid];
                state_d = (bus.flush[d_tid] || bus.drain_ack) ? DRN_IDLE : DRN_WAIT;
            end
            default: state_d = DRN_IDLE;
        endcase
    end

    assign bus.stb_cam_wptr_vld = st_acc;
    assign bus.stb_cam_rptr_vld = launch;
    assign bus.stb_cam_rw_tid   = st_acc ? bus.st_tid : gnt_tid;
    assign bus.stb_cam_rw_ptr   = st_acc ? wptr[bus.st_tid] : rptr[gnt_tid];
    assign bus.stb_cam_line_en  = valid[bus.cam_tid];
    assign bus.st_full          = full;
    assign bus.stb_empty        = empty;
    assign bus.drain_tid        = d_tid;
    assign bus.drain_ptr        = d_ptr;

    always_comb begin
        for (int t = 0; t < STB_THREADS; t++) begin
            wr[t]    = st_acc && bus.st_tid == tid_t'(t);
            rt[t]    = retire && d_tid == tid_t'(t);
            set_m[t] = wr[t] ? ptr_onehot(wptr[t]) : '0;
            clr_m[t] = rt[t] ? ptr_onehot(d_ptr) : '0;
        end
    end

    always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
            state_q <= DRN_IDLE;
            d_tid   <= '0;
            d_ptr   <= '0;
            rr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                d_tid <= gnt_tid;
                d_ptr <= rptr[gnt_tid];
            end
            if (retire) rr_ptr <= d_tid + tid_t'(1);
        end
    end

    // Flush wins over a same-cycle store or retire on that thread
    always_ff @(posedge l2clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < STB_THREADS; t++) begin
                wptr[t]  <= '0;
                rptr[t]  <= '0;
                cnt[t]   <= '0;
                valid[t] <= '0;
            end
        end else begin
            for (int t = 0; t < STB_THREADS; t++) begin
                if (bus.flush[t]) begin
                    wptr[t]  <= '0;
                    rptr[t]  <= '0;
                    cnt[t]   <= '0;
                    valid[t] <= '0;
                end else begin
                    if (wr[t]) wptr[t] <= wptr[t] + ptr_t'(1);
                    if (rt[t]) rptr[t] <= rptr[t] + ptr_t'(1);
                    cnt[t]   <= cnt[t] + cnt_t'(wr[t]) - cnt_t'(rt[t]);
                    valid[t] <= (valid[t] & ~clr_m[t]) | set_m[t];
                end
            end
        end
    end
endmodule

// File: tb/tb_stb_drain_ctl.sv
// tb_stb_drain_ctl: directed scenarios plus randomized traffic against a queue-based reference model
module tb_stb_drain_ctl;
    logic l2clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mq [8][$];
    int   mh [8];

    stb_drain_ctl_if bus ();

    stb_drain_ctl dut (
        .l2clk (l2clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 l2clk = ~l2clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t, required finish before 500000", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge l2clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.st_vld    = 1'b0;
        bus.st_tid    = 3'd0;
        bus.flush     = 8'h00;
        bus.drain_en  = 8'h00;
        bus.pcx_rdy   = 1'b0;
        bus.drain_ack = 1'b0;
        bus.cam_tid   = 3'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic store(input int tid);
        bus.st_vld = 1'b1;
        bus.st_tid = 3'(tid);
        tick();
        bus.st_vld = 1'b0;
    endtask

    task automatic drain_one(output int tid, output int ptr, output bit ok);
        ok  = 1'b0;
        tid = -1;
        ptr = -1;
        bus.pcx_rdy = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (bus.drain_vld) begin
                tid = int'(bus.drain_tid);
                ptr = int'(bus.drain_ptr);
                ok  = 1'b1;
                tick();
                bus.drain_ack = 1'b1;
                tick();
                bus.drain_ack = 1'b0;
            end else begin
                tick();
            end
        end
    endtask

    task automatic wait_drain_vld(output bit seen);
        seen = 1'b0;
        bus.pcx_rdy = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            #1;
            seen = bus.drain_vld;
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset        = 1'b1;
        bus.st_vld   = 1'b1;
        bus.st_tid   = 3'd3;
        bus.pcx_rdy  = 1'b1;
        bus.drain_en = 8'hFF;
        #1;
        n_chk++; if (bus.stb_cam_wptr_vld !== 1'b0) $display("FAIL rst_wptr_vld got %b want 0", bus.stb_cam_wptr_vld); else n_pass++;
        n_chk++; if (bus.stb_cam_rptr_vld !== 1'b0) $display("FAIL rst_rptr_vld got %b want 0", bus.stb_cam_rptr_vld); else n_pass++;
        n_chk++; if (bus.drain_vld !== 1'b0) $display("FAIL rst_drain_vld got %b want 0", bus.drain_vld); else n_pass++;
        n_chk++; if (bus.stb_empty !== 8'hFF) $display("FAIL rst_empty got %h want ff", bus.stb_empty); else n_pass++;
        n_chk++; if (bus.st_full !== 8'h00) $display("FAIL rst_full got %h want 00", bus.st_full); else n_pass++;
        tick();
        n_chk++; if (bus.stb_cam_wptr_vld !== 1'b0 || bus.stb_cam_line_en !== 8'h00)
            $display("FAIL rst_after_edge got wv=%b line=%h want 0/00", bus.stb_cam_wptr_vld, bus.stb_cam_line_en); else n_pass++;
        idle_inputs();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bus.st_vld = 1'b1;
            bus.st_tid = 3'd3;
            #1;
            n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rw_tid, bus.stb_cam_rw_ptr} !== {1'b1, 3'd3, 3'(i)})
                $display("FAIL fill_store%0d got wv=%b tid=%0d ptr=%0d want 1/3/%0d", i, bus.stb_cam_wptr_vld, bus.stb_cam_rw_tid, bus.stb_cam_rw_ptr, i); else n_pass++;
            tick();
        end
        bus.cam_tid = 3'd3;
        #1;
        n_chk++; if (bus.st_full !== 8'h08) $display("FAIL fill_full got %h want 08", bus.st_full); else n_pass++;
        n_chk++; if (bus.stb_empty !== 8'hF7) $display("FAIL fill_empty got %h want f7", bus.stb_empty); else n_pass++;
        n_chk++; if (bus.stb_cam_wptr_vld !== 1'b0) $display("FAIL fill_ninth_store got %b want 0", bus.stb_cam_wptr_vld); else n_pass++;
        n_chk++; if (bus.stb_cam_line_en !== 8'hFF) $display("FAIL fill_line_en got %h want ff", bus.stb_cam_line_en); else n_pass++;
        tick();
        bus.st_vld = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        store(2);
        bus.st_vld   = 1'b1;
        bus.st_tid   = 3'd1;
        bus.drain_en = 8'h04;
        bus.pcx_rdy  = 1'b1;
        #1;
        n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rptr_vld, bus.stb_cam_rw_tid} !== {1'b1, 1'b0, 3'd1})
            $display("FAIL prio_store_wins got wv=%b rv=%b tid=%0d want 1/0/1", bus.stb_cam_wptr_vld, bus.stb_cam_rptr_vld, bus.stb_cam_rw_tid); else n_pass++;
        tick();
        bus.st_vld = 1'b0;
        #1;
        n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rptr_vld, bus.stb_cam_rw_tid, bus.stb_cam_rw_ptr} !== {1'b0, 1'b1, 3'd2, 3'd0})
            $display("FAIL prio_read_next got wv=%b rv=%b tid=%0d ptr=%0d want 0/1/2/0", bus.stb_cam_wptr_vld, bus.stb_cam_rptr_vld, bus.stb_cam_rw_tid, bus.stb_cam_rw_ptr); else n_pass++;
        n_chk++; if (bus.drain_vld !== 1'b0) $display("FAIL prio_drain_early got %b want 0", bus.drain_vld); else n_pass++;
        tick();
        #1;
        n_chk++; if ({bus.drain_vld, bus.drain_tid, bus.drain_ptr} !== {1'b1, 3'd2, 3'd0})
            $display("FAIL prio_drain got vld=%b tid=%0d ptr=%0d want 1/2/0", bus.drain_vld, bus.drain_tid, bus.drain_ptr); else n_pass++;
        tick();
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        bus.cam_tid   = 3'd2;
        #1;
        n_chk++; if (bus.stb_empty !== 8'hFD || bus.stb_cam_line_en !== 8'h00)
            $display("FAIL prio_retired got empty=%h line=%h want fd/00", bus.stb_empty, bus.stb_cam_line_en); else n_pass++;
        tick();
    endtask

    task automatic test_rr_order();
        int exp_ord [3] = '{0, 2, 5};
        int tid, ptr;
        bit ok;
        do_reset();
        store(5);
        store(0);
        store(2);
        bus.drain_en = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            drain_one(tid, ptr, ok);
            n_chk++; if (!ok || tid != exp_ord[k] || ptr != 0)
                $display("FAIL rr_drain%0d got ok=%b tid=%0d ptr=%0d want 1/%0d/0", k, ok, tid, ptr, exp_ord[k]); else n_pass++;
        end
        #1;
        n_chk++; if (bus.stb_empty !== 8'hFF) $display("FAIL rr_all_empty got %h want ff", bus.stb_empty); else n_pass++;
        tick();
    endtask

    task automatic test_wrap();
        int tid, ptr;
        bit ok, all_ok;
        do_reset();
        for (int i = 0; i < 7; i++) store(4);
        bus.drain_en = 8'h10;
        all_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drain_one(tid, ptr, ok);
            if (!ok || ptr != i) all_ok = 1'b0;
        end
        n_chk++; if (!all_ok) $display("FAIL wrap_predrain got ok=0 want ok=1"); else n_pass++;
        bus.drain_en = 8'h00;
        bus.pcx_rdy  = 1'b0;
        bus.st_vld   = 1'b1;
        bus.st_tid   = 3'd4;
        #1;
        n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr} !== {1'b1, 3'd7})
            $display("FAIL wrap_store7 got wv=%b ptr=%0d want 1/7", bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr); else n_pass++;
        tick();
        bus.st_vld  = 1'b0;
        bus.cam_tid = 3'd4;
        #1;
        n_chk++; if (bus.stb_cam_line_en !== 8'h80) $display("FAIL wrap_line_en got %h want 80", bus.stb_cam_line_en); else n_pass++;
        bus.st_vld = 1'b1;
        #0;
        n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr} !== {1'b1, 3'd0})
            $display("FAIL wrap_wptr0 got wv=%b ptr=%0d want 1/0", bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr); else n_pass++;
        tick();
        bus.st_vld   = 1'b0;
        bus.drain_en = 8'h10;
        drain_one(tid, ptr, ok);
        n_chk++; if (!ok || ptr != 7) $display("FAIL wrap_drain7 got ok=%b ptr=%0d want 1/7", ok, ptr); else n_pass++;
        drain_one(tid, ptr, ok);
        n_chk++; if (!ok || ptr != 0) $display("FAIL wrap_rptr0 got ok=%b ptr=%0d want 1/0", ok, ptr); else n_pass++;
    endtask

    task automatic test_flush_wait();
        bit seen;
        do_reset();
        store(6);
        bus.drain_en = 8'h40;
        wait_drain_vld(seen);
        n_chk++; if (!seen) $display("FAIL flush_drain_seen got 0 want 1"); else n_pass++;
        bus.flush = 8'h40;
        tick();
        bus.flush     = 8'h00;
        bus.drain_en  = 8'h00;
        bus.cam_tid   = 3'd6;
        #1;
        n_chk++; if (bus.stb_empty[6] !== 1'b1 || bus.stb_cam_line_en !== 8'h00)
            $display("FAIL flush_cleared got empty6=%b line=%h want 1/00", bus.stb_empty[6], bus.stb_cam_line_en); else n_pass++;
        bus.drain_ack = 1'b1;
        bus.st_vld    = 1'b1;
        bus.st_tid    = 3'd6;
        #1;
        n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr} !== {1'b1, 3'd0})
            $display("FAIL flush_wptr_cleared got wv=%b ptr=%0d want 1/0", bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr); else n_pass++;
        tick();
        bus.st_vld = 1'b0;
        tick();
        bus.drain_ack = 1'b0;
        #1;
        n_chk++; if (bus.stb_empty[6] !== 1'b0 || bus.stb_cam_line_en !== 8'h01)
            $display("FAIL flush_ack_ignored got empty6=%b line=%h want 0/01", bus.stb_empty[6], bus.stb_cam_line_en); else n_pass++;
        tick();
    endtask

    task automatic test_same_cycle();
        int tid, ptr;
        bit seen, ok;
        do_reset();
        for (int i = 0; i < 3; i++) store(2);
        bus.drain_en = 8'h04;
        wait_drain_vld(seen);
        n_chk++; if (!seen) $display("FAIL same_drain_seen got 0 want 1"); else n_pass++;
        bus.drain_en  = 8'h00;
        bus.st_vld    = 1'b1;
        bus.st_tid    = 3'd2;
        bus.drain_ack = 1'b1;
        #1;
        n_chk++; if ({bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr} !== {1'b1, 3'd3})
            $display("FAIL same_store got wv=%b ptr=%0d want 1/3", bus.stb_cam_wptr_vld, bus.stb_cam_rw_ptr); else n_pass++;
        tick();
        bus.st_vld    = 1'b0;
        bus.drain_ack = 1'b0;
        bus.cam_tid   = 3'd2;
        #1;
        n_chk++; if (bus.stb_cam_line_en !== 8'h0E) $display("FAIL same_line_en got %h want 0e", bus.stb_cam_line_en); else n_pass++;
        bus.drain_en = 8'h04;
        for (int k = 1; k <= 3; k++) begin
            drain_one(tid, ptr, ok);
            n_chk++; if (!ok || ptr != k) $display("FAIL same_drain%0d got ok=%b ptr=%0d want 1/%0d", k, ok, ptr, k); else n_pass++;
        end
        #1;
        n_chk++; if (bus.stb_empty[2] !== 1'b1) $display("FAIL same_cnt3 got empty2=%b want 1", bus.stb_empty[2]); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_drain();
        bit seen;
        do_reset();
        store(0);
        bus.drain_en = 8'h01;
        wait_drain_vld(seen);
        n_chk++; if (!seen) $display("FAIL rmid_drain_seen got 0 want 1"); else n_pass++;
        #1;
        reset = 1'b1;
        #1;
        n_chk++; if (bus.drain_vld !== 1'b0 || bus.stb_empty !== 8'hFF || bus.stb_cam_line_en !== 8'h00)
            $display("FAIL rmid_async got dv=%b empty=%h line=%h want 0/ff/00", bus.drain_vld, bus.stb_empty, bus.stb_cam_line_en); else n_pass++;
        tick();
        reset         = 1'b0;
        bus.drain_ack = 1'b1;
        tick();
        bus.drain_ack = 1'b0;
        store(0);
        #1;
        n_chk++; if (bus.stb_empty !== 8'hFE || bus.stb_cam_line_en !== 8'h01)
            $display("FAIL rmid_restart got empty=%h line=%h want fe/01", bus.stb_empty, bus.stb_cam_line_en); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int win, wp, dt, dp, rr, mode, t;
        bit busy, rd, acc, retire;
        logic [7:0] ef, ee, el;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mq[i].delete();
            mh[i] = 0;
        end
        busy = 0; rd = 0; dt = 0; dp = 0; rr = 0;
        for (int cyc = 0; cyc < 1800; cyc++) begin
            mode          = (cyc / 300) % 3;
            bus.st_vld    = 1'($urandom_range(0, 1));
            bus.st_tid    = 3'(mode == 0 ? $urandom_range(0, 1) : $urandom_range(0, 7));
            for (int i = 0; i < 8; i++)
                bus.flush[i] = mode == 2 ? ($urandom_range(0, 15) == 0) : (mode == 1 ? ($urandom_range(0, 63) == 0) : 1'b0);
            bus.drain_en  = 8'($urandom | $urandom);
            bus.pcx_rdy   = mode == 0 ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) != 0);
            bus.drain_ack = 1'($urandom_range(0, 1));
            bus.cam_tid   = 3'($urandom_range(0, 7));
            #1;
            acc = bus.st_vld && mq[bus.st_tid].size() < 8 && !bus.flush[bus.st_tid];
            wp  = (mh[bus.st_tid] + mq[bus.st_tid].size()) % 8;
            win = -1;
            if (!busy && !acc && bus.pcx_rdy)
                for (int k = 0; k < 8; k++) begin
                    t = (rr + k) % 8;
                    if (win < 0 && mq[t].size() > 0 && bus.drain_en[t] && !bus.flush[t]) win = t;
                end
            for (int i = 0; i < 8; i++) begin
                ef[i] = mq[i].size() == 8;
                ee[i] = mq[i].size() == 0;
            end
            el = '0;
            foreach (mq[bus.cam_tid][j]) el[mq[bus.cam_tid][j]] = 1'b1;
            n_chk++; if (bus.stb_cam_wptr_vld !== acc) $display("FAIL rnd_wptr_vld cyc%0d got %b want %b", cyc, bus.stb_cam_wptr_vld, acc); else n_pass++;
            n_chk++; if (bus.stb_cam_rptr_vld !== (win >= 0)) $display("FAIL rnd_rptr_vld cyc%0d got %b want %b", cyc, bus.stb_cam_rptr_vld, win >= 0); else n_pass++;
            if (acc) begin
                n_chk++; if (bus.stb_cam_rw_tid !== bus.st_tid || bus.stb_cam_rw_ptr !== 3'(wp))
                    $display("FAIL rnd_wr_addr cyc%0d got %0d/%0d want %0d/%0d", cyc, bus.stb_cam_rw_tid, bus.stb_cam_rw_ptr, bus.st_tid, wp); else n_pass++;
            end
            if (win >= 0) begin
                n_chk++; if (bus.stb_cam_rw_tid !== 3'(win) || bus.stb_cam_rw_ptr !== 3'(mq[win][0]))
                    $display("FAIL rnd_rd_addr cyc%0d got %0d/%0d want %0d/%0d", cyc, bus.stb_cam_rw_tid, bus.stb_cam_rw_ptr, win, mq[win][0]); else n_pass++;
            end
            n_chk++; if (bus.drain_vld !== (busy && rd && !bus.flush[dt])) $display("FAIL rnd_drain_vld cyc%0d got %b want %b", cyc, bus.drain_vld, busy && rd && !bus.flush[dt]); else n_pass++;
            if (busy && rd && !bus.flush[dt]) begin
                n_chk++; if (bus.drain_tid !== 3'(dt) || bus.drain_ptr !== 3'(dp))
                    $display("FAIL rnd_drain cyc%0d got %0d/%0d want %0d/%0d", cyc, bus.drain_tid, bus.drain_ptr, dt, dp); else n_pass++;
            end
            n_chk++; if (bus.st_full !== ef) $display("FAIL rnd_full cyc%0d got %h want %h", cyc, bus.st_full, ef); else n_pass++;
            n_chk++; if (bus.stb_empty !== ee) $display("FAIL rnd_empty cyc%0d got %h want %h", cyc, bus.stb_empty, ee); else n_pass++;
            n_chk++; if (bus.stb_cam_line_en !== el) $display("FAIL rnd_line_en cyc%0d got %h want %h", cyc, bus.stb_cam_line_en, el); else n_pass++;
            retire = busy && !rd && bus.drain_ack && !bus.flush[dt];
            if (busy) begin
                if (bus.flush[dt]) busy = 0;
                else if (rd) rd = 0;
                else if (bus.drain_ack) busy = 0;
            end else if (win >= 0) begin
                busy = 1; rd = 1; dt = win; dp = mq[win][0];
            end
            if (retire) begin
                void'(mq[dt].pop_front());
                mh[dt] = (mh[dt] + 1) % 8;
                rr     = (dt + 1) % 8;
            end
            if (acc) mq[bus.st_tid].push_back(wp);
            for (int i = 0; i < 8; i++)
                if (bus.flush[i]) begin
                    mq[i].delete();
                    mh[i] = 0;
                end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_priority();
        test_rr_order();
        test_wrap();
        test_flush_wait();
        test_same_cycle();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
